tetris_control: RTL and testbench

Sequencing controller for the single-cell Tetris datapath. It turns the player's start, left, right and soft-drop requests plus a gravity timer into mutually exclusive one-cycle command strobes (`init_block`, `translate_down`, `translate_left`, `translate_right`). It reacts to the datapath's `just_fell` and `gg` flags to spawn the next piece or end the game. It sits between the debounced input logic and the datapath, and also keeps a landed-piece counter for the score display.

---
 rtl/tetris_control.sv | 123 ++++++++++++
 tb/tb_tetris_control.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_control.sv
// Sequencing controller for the single-cell Tetris datapath: turns start/move/drop
// requests and a gravity timer into one-cycle datapath command strobes.
module tetris_control #(
    parameter int GRAVITY_TICKS = 25_000_000,
    parameter int DROP_TICKS    = 2_500_000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        go_left,
    input  logic        go_right,
    input  logic        drop,
    input  logic        gg,
    input  logic        just_fell,
    output logic        dp_reset,
    output logic        init_block,
    output logic        translate_down,
    output logic        translate_left,
    output logic        translate_right,
    output logic        playing,
    output logic        game_over,
    output logic [15:0] pieces
);

    localparam int CNT_W = $clog2(GRAVITY_TICKS);
    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_TICKS - 1);
    localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_TICKS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CLEAR     = 3'd1;
    localparam logic [2:0] SPAWN     = 3'd2;
    localparam logic [2:0] SPAWN_CHK = 3'd3;
    localparam logic [2:0] FALL      = 3'd4;
    localparam logic [2:0] DOWN_CHK  = 3'd5;
    localparam logic [2:0] OVER      = 3'd6;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic             drop_q;
    logic             pend_l;
    logic             pend_r;
    logic             tick;
    logic             move_ok;
    logic             accept;
    logic             pend_clr;

    // Every strobe is decoded from registered state only, so no input reaches an output.
    always_comb begin
        tick     = (state == FALL) && (cnt >= (drop_q ? DROP_LAST : GRAV_LAST));
        move_ok  = (state == FALL) && !tick;
        accept   = (state == SPAWN) || (state == SPAWN_CHK) ||
                   (state == FALL)  || (state == DOWN_CHK);
        pend_clr = (state == CLEAR) || move_ok || ((state == DOWN_CHK) && just_fell);
    end

    always_comb begin
        dp_reset        = (state == CLEAR);
        init_block      = (state == SPAWN);
        translate_down  = tick;
        translate_left  = move_ok && pend_l && !pend_r;
        translate_right = move_ok && pend_r && !pend_l;
        playing         = (state == CLEAR) || accept;
        game_over       = (state == OVER);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = CLEAR;
            CLEAR:     state_next = SPAWN;
            SPAWN:     state_next = SPAWN_CHK;
            SPAWN_CHK: state_next = gg ? OVER : FALL;
            FALL:      if (tick) state_next = DOWN_CHK;
            DOWN_CHK:  state_next = just_fell ? SPAWN : FALL;
            OVER:      if (start) state_next = CLEAR;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            drop_q <= 1'b0;
        end else begin
            state  <= state_next;
            drop_q <= drop;
        end
    end

    // Counter is zero on entry to FALL and holds zero through DOWN_CHK.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if ((state == CLEAR) || (state == SPAWN_CHK)) begin
            cnt <= '0;
        end else if (state == FALL) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // A move request arriving in the same cycle as a clear survives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_l <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            pend_l <= (pend_l && !pend_clr) || (accept && go_left);
            pend_r <= (pend_r && !pend_clr) || (accept && go_right);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pieces <= 16'h0000;
        end else if (state == CLEAR) begin
            pieces <= 16'h0000;
        end else if ((state == DOWN_CHK) && just_fell && (pieces != 16'hFFFF)) begin
            pieces <= pieces + 16'h0001;
        end
    end

endmodule

// File: tb/tb_tetris_control.sv
// Bench for tetris_control: directed timing scenarios plus randomized play
// compared cycle by cycle against a rule-level reference model.
module tb_tetris_control;

    localparam int GT = 4;
    localparam int DT = 2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        go_left = 1'b0;
    logic        go_right = 1'b0;
    logic        drop = 1'b0;
    logic        gg = 1'b0;
    logic        just_fell = 1'b0;
    logic        dp_reset;
    logic        init_block;
    logic        translate_down;
    logic        translate_left;
    logic        translate_right;
    logic        playing;
    logic        game_over;
    logic [15:0] pieces;

    logic [4:0]  strb;
    logic [22:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {M_IDLE, M_CLEAR, M_SPAWN, M_CHK, M_FALL, M_DCHK, M_OVER} mstate_t;
    mstate_t m_state;
    int      m_cnt;
    int      m_pieces;
    bit      m_dq;
    bit      m_pl;
    bit      m_pr;

    tetris_control #(
        .GRAVITY_TICKS(GT),
        .DROP_TICKS   (DT)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .go_left        (go_left),
        .go_right       (go_right),
        .drop           (drop),
        .gg             (gg),
        .just_fell      (just_fell),
        .dp_reset       (dp_reset),
        .init_block     (init_block),
        .translate_down (translate_down),
        .translate_left (translate_left),
        .translate_right(translate_right),
        .playing        (playing),
        .game_over      (game_over),
        .pieces         (pieces)
    );

    always #5 clock = ~clock;

    assign strb = {dp_reset, init_block, translate_down, translate_left, translate_right};
    assign obs  = {strb, playing, game_over, pieces};

    always @(negedge clock) begin
        if (resetn) begin
            n_checks++;
            if ($countones(strb) > 1) begin
                n_fail++;
                $display("FAIL one_strobe: strobes=%b required at most one high", strb);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        {start, go_left, go_right, drop, gg, just_fell} = '0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    // Leaves the bench at the negedge of the first FALL cycle of a new game.
    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_tick();
        return (m_state == M_FALL) && (m_cnt >= (m_dq ? DT : GT) - 1);
    endfunction

    function automatic logic [22:0] m_out();
        bit t;
        bit mv;
        bit play;
        t    = m_tick();
        mv   = (m_state == M_FALL) && !t;
        play = m_state inside {M_CLEAR, M_SPAWN, M_CHK, M_FALL, M_DCHK};
        return {m_state == M_CLEAR, m_state == M_SPAWN, t, mv && m_pl && !m_pr,
                mv && m_pr && !m_pl, play, m_state == M_OVER, 16'(m_pieces)};
    endfunction

    function automatic void m_step(bit st, bit gl, bit gr, bit dr, bit g, bit jf);
        bit t;
        bit take;
        t    = m_tick();
        take = m_state inside {M_SPAWN, M_CHK, M_FALL, M_DCHK};
        case (m_state)
            M_IDLE:  if (st) m_state = M_CLEAR;
            M_CLEAR: begin
                m_cnt = 0; m_pl = 0; m_pr = 0; m_pieces = 0;
                m_state = M_SPAWN;
            end
            M_SPAWN: m_state = M_CHK;
            M_CHK: begin
                if (g) m_state = M_OVER;
                else begin m_state = M_FALL; m_cnt = 0; end
            end
            M_FALL: begin
                if (t) begin m_cnt = 0; m_state = M_DCHK; end
                else begin m_cnt++; m_pl = 0; m_pr = 0; end
            end
            M_DCHK: begin
                if (jf) begin
                    if (m_pieces < 65535) m_pieces++;
                    m_pl = 0; m_pr = 0;
                    m_state = M_SPAWN;
                end else m_state = M_FALL;
            end
            M_OVER:  if (st) m_state = M_CLEAR;
            default: m_state = M_IDLE;
        endcase
        if (take && gl) m_pl = 1;
        if (take && gr) m_pr = 1;
        m_dq = dr;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        {start, go_left, go_right, drop, gg, just_fell} = 6'b111111;
        step();
        n_checks++;
        if (obs !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", obs);
        end
        do_reset();
        n_checks++;
        if (obs !== 23'h0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %h required 0", obs);
        end
    endtask

    task automatic test_start_gravity();
        logic [4:0] exp;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int off = 1; off <= 17; off++) begin
            exp = 5'b00000;
            if (off == 1) exp = 5'b10000;
            if (off == 2) exp = 5'b01000;
            if (off == 7 || off == 12 || off == 17) exp = 5'b00100;
            n_checks++;
            if ({strb, playing} !== {exp, 1'b1}) begin
                n_fail++;
                $display("FAIL start_gravity off=%0d: strobes,playing=%b required %b", off, {strb, playing}, {exp, 1'b1});
            end
            if (off < 17) step();
        end
    endtask

    task automatic test_landing();
        do_reset();
        start_game();
        step(); step(); step();
        n_checks++;
        if (strb !== 5'b00100) begin
            n_fail++;
            $display("FAIL landing_down: strobes=%b required 00100", strb);
        end
        just_fell = 1'b1;
        step();
        step();
        just_fell = 1'b0;
        n_checks++;
        if ({strb, pieces} !== {5'b01000, 16'd1}) begin
            n_fail++;
            $display("FAIL landing_spawn: strobes=%b pieces=%0d required 01000 / 1", strb, pieces);
        end
        force dut.pieces = 16'hFFFF;
        step();
        release dut.pieces;
        step();
        step(); step(); step();
        just_fell = 1'b1;
        step();
        step();
        just_fell = 1'b0;
        n_checks++;
        if ({strb, pieces} !== {5'b01000, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL pieces_saturate: strobes=%b pieces=%h required 01000 / ffff", strb, pieces);
        end
    endtask

    task automatic test_moves();
        do_reset();
        start_game();
        go_left = 1'b1;
        step();
        go_left = 1'b0;
        n_checks++;
        if (strb !== 5'b00010) begin
            n_fail++;
            $display("FAIL move_left: strobes=%b required 00010", strb);
        end
        go_left = 1'b1;
        go_right = 1'b1;
        step();
        go_left = 1'b0;
        go_right = 1'b0;
        n_checks++;
        if (strb !== 5'b00000) begin
            n_fail++;
            $display("FAIL move_both: strobes=%b required 00000", strb);
        end
        step();
        n_checks++;
        if (strb !== 5'b00100) begin
            n_fail++;
            $display("FAIL move_then_tick: strobes=%b required 00100", strb);
        end
        step();
        step();
        n_checks++;
        if (strb !== 5'b00000) begin
            n_fail++;
            $display("FAIL move_both_cleared: strobes=%b required 00000", strb);
        end
    endtask

    task automatic test_tick_priority();
        do_reset();
        start_game();
        step(); step(); step();
        go_right = 1'b1;
        n_checks++;
        if (strb !== 5'b00100) begin
            n_fail++;
            $display("FAIL prio_down: strobes=%b required 00100", strb);
        end
        step();
        go_right = 1'b0;
        n_checks++;
        if (strb !== 5'b00000) begin
            n_fail++;
            $display("FAIL prio_downchk: strobes=%b required 00000", strb);
        end
        step();
        n_checks++;
        if (strb !== 5'b00001) begin
            n_fail++;
            $display("FAIL prio_right: strobes=%b required 00001", strb);
        end
        step();
        n_checks++;
        if (strb !== 5'b00000) begin
            n_fail++;
            $display("FAIL prio_right_once: strobes=%b required 00000", strb);
        end
    endtask

    task automatic test_game_over();
        int bad;
        do_reset();
        start_game();
        step(); step(); step();
        just_fell = 1'b1;
        step();
        step();
        just_fell = 1'b0;
        gg = 1'b1;
        step();
        step();
        gg = 1'b0;
        n_checks++;
        if ({game_over, playing, pieces} !== {2'b10, 16'd1}) begin
            n_fail++;
            $display("FAIL over_enter: game_over,playing=%b pieces=%0d required 10 / 1", {game_over, playing}, pieces);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            go_left   = 1'($urandom_range(0, 1));
            go_right  = 1'($urandom_range(0, 1));
            drop      = 1'($urandom_range(0, 1));
            just_fell = 1'($urandom_range(0, 1));
            step();
            if ({strb, game_over, pieces} !== {5'b00000, 1'b1, 16'd1}) bad++;
        end
        {go_left, go_right, drop, just_fell} = '0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL over_quiet: %0d bad cycles required 0", bad);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({strb, game_over, playing} !== 7'b1000001) begin
            n_fail++;
            $display("FAIL over_restart: strobes,over,playing=%b required 1000001", {strb, game_over, playing});
        end
        step();
        n_checks++;
        if ({strb, pieces} !== {5'b01000, 16'd0}) begin
            n_fail++;
            $display("FAIL restart_pieces: strobes=%b pieces=%0d required 01000 / 0", strb, pieces);
        end
    endtask

    task automatic test_reset_midgame();
        do_reset();
        start_game();
        step(); step(); step();
        just_fell = 1'b1;
        step();
        step();
        just_fell = 1'b0;
        step(); step();
        go_left = 1'b1;
        step(); step(); step();
        go_left = 1'b0;
        step();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (obs !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_midgame: got %h required 0", obs);
        end
        step();
        step();
        resetn = 1'b1;
        step();
        n_checks++;
        if (obs !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %h required 0", obs);
        end
    endtask

    task automatic test_random();
        logic [22:0] exp;
        int bad;
        do_reset();
        m_state  = M_IDLE;
        m_cnt    = 0;
        m_pieces = 0;
        m_dq     = 0;
        m_pl     = 0;
        m_pr     = 0;
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            exp = m_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                if (bad < 10) $display("FAIL random cyc=%0d: got %h required %h", i, obs, exp);
                bad++;
            end
            start     = ($urandom_range(0, 19) == 0);
            go_left   = ($urandom_range(0, 5) == 0);
            go_right  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) drop = ~drop;
            gg        = ($urandom_range(0, 7) == 0);
            just_fell = ($urandom_range(0, 2) == 0);
            m_step(start, go_left, go_right, drop, gg, just_fell);
            step();
        end
        {start, go_left, go_right, drop, gg, just_fell} = '0;
    endtask

    initial begin
        step();
        test_reset();
        test_start_gravity();
        test_landing();
        test_moves();
        test_tick_priority();
        test_game_over();
        test_reset_midgame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
